// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I types for the front end (instruction word, field view, fetch entry).
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package rv32_pkg;

  localparam logic [31:0] RV32_INST_BYTES = 32'd4;

  typedef logic [31:0] rv32_inst_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32_fields_t;

  typedef struct packed {
    logic [31:0] pc;
    rv32_inst_t  inst;
  } rv32_fetch_entry_t;

  // R-type field view of a raw word; decode picks the fields it needs per opcode.
  function automatic rv32_fields_t rv32_get_fields(input rv32_inst_t inst);
    return rv32_fields_t'(inst);
  endfunction

endpackage

// File: rtl/rv32_fetch_buffer.sv
// rv32_fetch_buffer: synchronous FIFO of {pc, inst} entries between fetch and decode.
// Latency: 1 cycle push-to-head; head is a plain array read at rd_ptr.
// Backpressure: none internally; the writer must only push when a slot is free (or popping).
// Ports: clk/rst (sync, active-high), flush (clears all entries, beats push/pop),
//        push/push_entry, pop, empty, head, count (entries held, for upstream credit).
module rv32_fetch_buffer
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  rv32_fetch_entry_t      push_entry,
  input  logic                   pop,
  output logic                   empty,
  output rv32_fetch_entry_t      head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW + 1)'(1);

  rv32_fetch_entry_t mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push on a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible after it has been written.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/rv32_fetch_stage.sv
// rv32_fetch_stage: in-order RV32I fetch; owns the PC, tracks in-flight reads, drops stale ones.
// Latency: memory response to out_valid is 1 cycle minimum (registered buffer, no bypass).
// Backpressure: out_ready low fills the buffer; requests stop once in-flight + buffered hits depth.
// Ports: clk/rst (sync, active-high); mem_req_* word request (valid/ready); mem_resp_* in-order
//        responses (never stalled); redirect_* new PC; out_* {pc, inst} to decode (valid/ready).
module rv32_fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = ((OW > CW) ? OW : CW) + 1;
  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH  = SW'(FIFO_DEPTH);

  logic [31:0]       pc, resp_pc, redirect_aligned;
  logic [OW-1:0]     outstanding, discard;
  logic [CW-1:0]     buf_count;
  logic [SW-1:0]     live_sum;
  logic              buf_empty;
  rv32_fetch_entry_t buf_head, push_entry;
  logic              req_fire, resp_fire, drop, push, pop;
  logic              unused_ok;

  assign unused_ok        = &{1'b0, redirect_pc[1:0]};
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign mem_resp_ready   = 1'b1;
  assign resp_fire        = mem_resp_valid;

  // Responses that will actually land in the buffer plus what is already there;
  // keeping this below depth means every accepted response has a slot waiting.
  assign live_sum      = SW'(outstanding) - SW'(discard) + SW'(buf_count);
  assign mem_req_valid = !rst && !redirect_valid && (outstanding < MAX_OS) && (live_sum < DEPTH);
  assign mem_req_addr  = pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign drop       = resp_fire && (discard != '0);
  assign push       = resp_fire && !drop && !redirect_valid;
  assign pop        = !buf_empty && out_ready && !redirect_valid;
  assign push_entry = {resp_pc, mem_resp_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_ADDR;
      resp_pc     <= RESET_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // Every response still owed by memory belongs to the old stream.
      pc          <= redirect_aligned;
      resp_pc     <= redirect_aligned;
      outstanding <= outstanding - OW'(resp_fire);
      discard     <= outstanding - OW'(resp_fire);
    end else begin
      if (req_fire) pc <= pc + RV32_INST_BYTES;
      if (push)     resp_pc <= resp_pc + RV32_INST_BYTES;
      if (drop)     discard <= discard - OW'(1);
      unique case ({req_fire, resp_fire})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // A response with nothing in flight means the memory broke ordering or invented data.
  always_ff @(posedge clk) begin
    if (!rst && mem_resp_valid) assert (outstanding != '0);
  end

  rv32_fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .empty      (buf_empty),
    .head       (buf_head),
    .count      (buf_count)
  );

  assign out_valid = !buf_empty;
  assign out_pc    = buf_head.pc;
  assign out_inst  = buf_head.inst;

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// tb_rv32_fetch_stage: directed scenarios with an in-order latency memory model and an output scoreboard.
// Latency: n/a (bench).
// Backpressure: driven directly through out_ready and mem_req_ready.
module tb_rv32_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;

  // Second instance only checks request addresses across the 32-bit wrap from its reset PC.
  logic        w_req_valid, w_resp_ready, w_out_valid;
  logic [31:0] w_req_addr, w_out_pc, w_out_inst;
  logic        w_req_ready = 1'b1;
  logic        w_resp_valid = 1'b0;
  logic [31:0] w_resp_data = 32'h0;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_out_ready = 1'b0;

  rv32_fetch_stage #(.RESET_ADDR(32'h0), .FIFO_DEPTH(4), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  rv32_fetch_stage #(.RESET_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(4), .MAX_OUTSTANDING(4)) u_wrap (
    .clk(clk), .rst(rst),
    .mem_req_valid(w_req_valid), .mem_req_ready(w_req_ready), .mem_req_addr(w_req_addr),
    .mem_resp_valid(w_resp_valid), .mem_resp_ready(w_resp_ready), .mem_resp_data(w_resp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc), .out_inst(w_out_inst)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend[$];
  logic [31:0] w_addrs[$];
  int unsigned total = 0, bad = 0;
  int unsigned lat = 1, cyc = 0, fires = 0;
  int unsigned mcyc = 0, npops = 0, first_pop = 0, last_pop = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_stream(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = start + 32'(4 * i);
      e.inst = inst_of(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0; mem_req_ready = 1'b1;
    exp_q.delete();
    #1 chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    fires = 0;
    rst = 1'b0;
    #1;
    chk("post_rst_req_valid", 32'(mem_req_valid), 32'd1);
    chk("post_rst_req_addr", mem_req_addr, 32'h0);
  endtask

  // Memory: in-order, fixed latency 'lat' edges from request acceptance to response.
  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = inst_of(pend[0].addr);
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
      end
      #3;
      if (rst) begin
        pend.delete();
      end else begin
        if (mem_req_valid && mem_req_ready) begin
          pend.push_back('{addr: mem_req_addr, due: cyc + lat});
          fires++;
          chk("req_addr_align", {30'b0, mem_req_addr[1:0]}, 32'h0);
        end
        if (mem_resp_valid) void'(pend.pop_front());
      end
      cyc++;
    end
  end

  // Scoreboard monitor: every accepted output must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      mcyc++;
      if (!rst && out_valid && out_ready && !redirect_valid) begin
        if (npops == 0) first_pop = mcyc;
        last_pop = mcyc;
        npops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected actual pc=%h required=none", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_inst", out_inst, e.inst);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst && w_req_valid && w_req_ready && w_addrs.size() < 4) w_addrs.push_back(w_req_addr);
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; mem_req_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b0;

    // Streaming: 1-cycle memory, decode always ready, one output per cycle once primed.
    lat = 1;
    do_reset();
    out_ready = 1'b1;
    npops = 0;
    expect_stream(32'h0, 16);
    wait_drain("drain_stream", 100);
    out_ready = 1'b0;
    chk("throughput_span", 32'(last_pop - first_pop), 32'd15);

    // Backpressure: buffer fills to depth, requests stop, nothing is lost.
    lat = 1;
    do_reset();
    repeat (20) @(negedge clk);
    chk("bp_fires", 32'(fires), 32'd4);
    chk("bp_req_valid", 32'(mem_req_valid), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    expect_stream(32'h0, 8);
    out_ready = 1'b1;
    wait_drain("drain_bp", 100);
    out_ready = 1'b0;

    // Redirect with three requests in flight on a 3-cycle memory.
    lat = 3;
    do_reset();
    out_ready = 1'b1;
    n = 0;
    while (fires < 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("c_fires", 32'(fires), 32'd3);
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    exp_q.delete();
    expect_stream(32'h100, 8);
    #1 chk("c_redirect_req_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    chk("c_next_req_valid", 32'(mem_req_valid), 32'd1);
    chk("c_next_req_addr", mem_req_addr, 32'h100);
    wait_drain("drain_redirect", 100);
    out_ready = 1'b0;

    // Redirect coinciding with a response and a decode pop.
    lat = 2;
    do_reset();
    out_ready = 1'b1;
    expect_stream(32'h0, 16);
    repeat (7) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    #2;
    chk("d_resp_same_cycle", 32'(mem_resp_valid), 32'd1);
    chk("d_pop_same_cycle", 32'(out_valid), 32'd1);
    chk("d_pops_before", 32'(exp_q.size()), 32'd12);
    exp_q.delete();
    expect_stream(32'h200, 8);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("d_flush_empty", 32'(out_valid), 32'd0);
    wait_drain("drain_collide", 100);
    out_ready = 1'b0;

    // Unaligned redirect onto a full buffer: low PC bits are ignored.
    repeat (10) @(negedge clk);
    chk("e_full_before", 32'(out_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    exp_q.delete();
    expect_stream(32'h200, 8);
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #1 chk("e_req_addr", mem_req_addr, 32'h200);
    wait_drain("drain_unaligned", 100);
    out_ready = 1'b0;

    // Fetch and response PCs wrap through zero.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    exp_q.delete();
    expect_stream(32'hFFFF_FFF8, 5);
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("drain_wrap", 100);
    out_ready = 1'b0;

    // Wrap instance: reset PC near the top, requests stop at the in-flight limit.
    chk("w_req_count", 32'(w_addrs.size()), 32'd4);
    if (w_addrs.size() == 4) begin
      chk("w_addr0", w_addrs[0], 32'hFFFF_FFF8);
      chk("w_addr1", w_addrs[1], 32'hFFFF_FFFC);
      chk("w_addr2", w_addrs[2], 32'h0000_0000);
      chk("w_addr3", w_addrs[3], 32'h0000_0004);
    end
    chk("w_req_stalled", 32'(w_req_valid), 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
